// File: rtl/program_counter.sv
// program_counter: WIDTH-bit PC with load/inc and optional DEPTH-entry return-address stack (PC_RETURN_STACK_EN).
// Latency: every control acts on the edge it is sampled; out is registered and valid after that edge.
// Backpressure: none; stack overflow/underflow requests are dropped and latched in sticky stack_err.
module program_counter #(
   parameter int                 WIDTH        = 16,
   parameter int                 DEPTH        = 8,
   parameter logic [WIDTH-1:0]   RESET_VECTOR = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   input  logic             load,
   input  logic             inc,
   input  logic             call,
   input  logic             ret,
   output logic [WIDTH-1:0] out,
   output logic             stack_full,
   output logic             stack_empty,
   output logic             stack_err
);

   logic [WIDTH-1:0] out_nxt;
   logic [WIDTH-1:0] out_plus1;

   assign out_plus1 = out + WIDTH'(1);

`ifdef PC_RETURN_STACK_EN

   localparam int             SPW     = $clog2(DEPTH + 1);
   localparam int             AW      = $clog2(DEPTH);
   localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

   logic [WIDTH-1:0] stk [DEPTH];
   logic [SPW-1:0]   sp;
   logic [SPW-1:0]   sp_nxt;
   logic [SPW-1:0]   sp_m1;
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    rd_idx;
   logic             err_nxt;
   logic             push;

   // sp addresses the next free slot, so a push writes stk[sp] and a pop reads stk[sp-1]
   assign sp_m1  = sp - SPW'(1);
   assign wr_idx = sp[AW-1:0];
   assign rd_idx = sp_m1[AW-1:0];

   assign stack_full  = (sp == SP_FULL);
   assign stack_empty = (sp == '0);

   // next-state select: ret > call > load > inc > hold; only the winning request acts
   always_comb begin
      out_nxt = out;
      sp_nxt  = sp;
      err_nxt = stack_err;
      push    = 1'b0;
      if (ret) begin
         if (sp != '0) begin
            out_nxt = stk[rd_idx];
            sp_nxt  = sp_m1;
         end else begin
            err_nxt = 1'b1;
         end
      end else if (call) begin
         if (sp != SP_FULL) begin
            push    = 1'b1;
            out_nxt = in;
            sp_nxt  = sp + SPW'(1);
         end else begin
            err_nxt = 1'b1;
         end
      end else if (load) begin
         out_nxt = in;
      end else if (inc) begin
         out_nxt = out_plus1;
      end
   end

   // pc, stack pointer and sticky error register; reset discards any in-flight calls
   always_ff @(posedge clk) begin
      if (reset) begin
         out       <= RESET_VECTOR;
         sp        <= '0;
         stack_err <= 1'b0;
      end else begin
         out       <= out_nxt;
         sp        <= sp_nxt;
         stack_err <= err_nxt;
      end
   end

   // return-address storage; contents need no reset because sp gates every read
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         stk[wr_idx] <= out_plus1;
      end
   end

`else

   logic unused_ret;

   // ret has no meaning without a stack and is deliberately ignored
   assign unused_ret  = ret;
   assign stack_full  = 1'b0;
   assign stack_empty = 1'b1;
   assign stack_err   = 1'b0;

   // next-state select: call degenerates to a plain jump, sharing load's priority slot
   always_comb begin
      out_nxt = out;
      if (call || load) begin
         out_nxt = in;
      end else if (inc) begin
         out_nxt = out_plus1;
      end
   end

   // pc register
   always_ff @(posedge clk) begin
      if (reset) begin
         out <= RESET_VECTOR;
      end else begin
         out <= out_nxt;
      end
   end

`endif

endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: randomized and directed checks of program_counter against a queue-based model.
// Inputs change #1 after each rising edge; outputs are sampled at that same point.
// The model follows whichever build (PC_RETURN_STACK_EN or not) the RTL was compiled with.
module tb_program_counter;

   localparam int          WIDTH = 16;
   localparam int          DEPTH = 8;
   localparam logic [15:0] RV    = 16'h0000;

   logic        clk = 1'b0;
   logic        reset, load, inc, call, ret;
   logic [15:0] in;
   logic [15:0] out;
   logic        stack_full, stack_empty, stack_err;

   int pass_n  = 0;
   int check_n = 0;

   // behavioural model state
   logic [15:0] m_pc;
   logic [15:0] m_stk[$];
   logic        m_err;

   program_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
      .clk(clk), .reset(reset), .in(in), .load(load), .inc(inc), .call(call), .ret(ret),
      .out(out), .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
   );

   always #5 clk = ~clk;

   task automatic model_step(input logic r, ld, ic, cl, rt, input logic [15:0] d);
      if (r) begin
         m_pc = RV;
         m_stk.delete();
         m_err = 1'b0;
      end else begin
`ifdef PC_RETURN_STACK_EN
         if (rt) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else m_err = 1'b1;
         end else if (cl) begin
            if (m_stk.size() < DEPTH) begin
               m_stk.push_back(m_pc + 16'd1);
               m_pc = d;
            end else begin
               m_err = 1'b1;
            end
         end else if (ld) m_pc = d;
         else if (ic) m_pc = m_pc + 16'd1;
`else
         if (cl || ld) m_pc = d;
         else if (ic) m_pc = m_pc + 16'd1;
`endif
      end
   endtask

   task automatic drive(input logic r, ld, ic, cl, rt, input logic [15:0] d);
      reset = r; load = ld; inc = ic; call = cl; ret = rt; in = d;
      model_step(r, ld, ic, cl, rt, d);
      @(posedge clk);
      #1;
      reset = 1'b0; load = 1'b0; inc = 1'b0; call = 1'b0; ret = 1'b0;
   endtask

   task automatic test_reset;
      drive(1, 0, 0, 0, 0, 16'h0);
      check_n++; if (out !== 16'h0000) $display("FAIL reset_out got=%h exp=0000", out); else pass_n++;
      check_n++; if (stack_empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", stack_empty); else pass_n++;
      check_n++; if (stack_full !== 1'b0) $display("FAIL reset_full got=%b exp=0", stack_full); else pass_n++;
      check_n++; if (stack_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", stack_err); else pass_n++;
      for (int i = 1; i <= 3; i++) begin
         drive(0, 0, 1, 0, 0, 16'h0);
         check_n++; if (out !== 16'(i)) $display("FAIL inc_seq got=%h exp=%h", out, 16'(i)); else pass_n++;
      end
      drive(1, 0, 1, 1, 0, 16'h5555);
      check_n++; if (out !== 16'h0000) $display("FAIL mid_reset got=%h exp=0000", out); else pass_n++;
   endtask

   task automatic test_wrap;
      drive(0, 1, 0, 0, 0, 16'hFFFE);
      check_n++; if (out !== 16'hFFFE) $display("FAIL load got=%h exp=fffe", out); else pass_n++;
      drive(0, 0, 1, 0, 0, 16'h0);
      check_n++; if (out !== 16'hFFFF) $display("FAIL inc_ffff got=%h exp=ffff", out); else pass_n++;
      drive(0, 0, 1, 0, 0, 16'h0);
      check_n++; if (out !== 16'h0000) $display("FAIL wrap got=%h exp=0000", out); else pass_n++;
      check_n++; if (stack_err !== 1'b0) $display("FAIL wrap_err got=%b exp=0", stack_err); else pass_n++;
   endtask

   task automatic test_call_ret;
      drive(0, 1, 0, 0, 0, 16'h0010);
      drive(0, 0, 0, 1, 0, 16'h0100);
      check_n++; if (out !== 16'h0100) $display("FAIL call_target got=%h exp=0100", out); else pass_n++;
      drive(0, 0, 1, 0, 0, 16'h0);
      check_n++; if (out !== 16'h0101) $display("FAIL call_inc got=%h exp=0101", out); else pass_n++;
      drive(0, 0, 0, 0, 1, 16'h0);
`ifdef PC_RETURN_STACK_EN
      check_n++; if (out !== 16'h0011) $display("FAIL ret_addr got=%h exp=0011", out); else pass_n++;
`else
      check_n++; if (out !== 16'h0101) $display("FAIL ret_ignored got=%h exp=0101", out); else pass_n++;
`endif
      check_n++; if (stack_empty !== 1'b1) $display("FAIL ret_empty got=%b exp=1", stack_empty); else pass_n++;
   endtask

   task automatic test_stack_depth;
      logic [15:0] exp_pc;
      drive(1, 0, 0, 0, 0, 16'h0);
      drive(0, 1, 0, 0, 0, 16'h0200);
      for (int i = 0; i < 9; i++) begin
         drive(0, 0, 0, 1, 0, 16'h1000 + 16'(i * 16));
`ifdef PC_RETURN_STACK_EN
         exp_pc = (i < 8) ? 16'h1000 + 16'(i * 16) : 16'h1070;
`else
         exp_pc = 16'h1000 + 16'(i * 16);
`endif
         check_n++; if (out !== exp_pc) $display("FAIL call_%0d got=%h exp=%h", i, out, exp_pc); else pass_n++;
         check_n++;
         if (stack_full !== (m_stk.size() == DEPTH))
            $display("FAIL full_%0d got=%b exp=%b", i, stack_full, m_stk.size() == DEPTH);
         else pass_n++;
         check_n++; if (stack_err !== m_err) $display("FAIL err_%0d got=%b exp=%b", i, stack_err, m_err); else pass_n++;
      end
`ifdef PC_RETURN_STACK_EN
      check_n++; if (stack_err !== 1'b1) $display("FAIL overflow_err got=%b exp=1", stack_err); else pass_n++;
      for (int j = 0; j < 9; j++) begin
         drive(0, 0, 0, 0, 1, 16'h0);
         exp_pc = (j >= 7) ? 16'h0201 : 16'h1001 + 16'((6 - j) * 16);
         check_n++; if (out !== exp_pc) $display("FAIL unwind_%0d got=%h exp=%h", j, out, exp_pc); else pass_n++;
      end
      check_n++; if (stack_err !== 1'b1) $display("FAIL underflow_err got=%b exp=1", stack_err); else pass_n++;
      check_n++; if (stack_empty !== 1'b1) $display("FAIL unwind_empty got=%b exp=1", stack_empty); else pass_n++;
`else
      drive(0, 0, 0, 0, 1, 16'h0);
      check_n++; if (out !== 16'h1080) $display("FAIL ret_hold got=%h exp=1080", out); else pass_n++;
      check_n++; if (stack_empty !== 1'b1) $display("FAIL const_empty got=%b exp=1", stack_empty); else pass_n++;
`endif
   endtask

   task automatic test_simultaneous;
      drive(1, 0, 0, 0, 0, 16'h0);
      drive(0, 1, 1, 0, 0, 16'h1234);
      check_n++; if (out !== 16'h1234) $display("FAIL load_inc got=%h exp=1234", out); else pass_n++;
      drive(0, 0, 0, 1, 0, 16'h0300);
      drive(0, 0, 0, 1, 1, 16'h0400);
`ifdef PC_RETURN_STACK_EN
      check_n++; if (out !== 16'h1235) $display("FAIL call_ret got=%h exp=1235", out); else pass_n++;
      check_n++; if (stack_empty !== 1'b1) $display("FAIL call_ret_empty got=%b exp=1", stack_empty); else pass_n++;
`else
      check_n++; if (out !== 16'h0400) $display("FAIL call_ret got=%h exp=0400", out); else pass_n++;
`endif
      check_n++; if (stack_err !== 1'b0) $display("FAIL call_ret_err got=%b exp=0", stack_err); else pass_n++;
   endtask

   task automatic test_random;
      logic r, ld, ic, cl, rt;
      logic [15:0] d;
      drive(1, 0, 0, 0, 0, 16'h0);
      for (int n = 0; n < 400; n++) begin
         r  = ($urandom_range(0, 59) == 0);
         ld = ($urandom_range(0, 3) == 0);
         ic = ($urandom_range(0, 1) == 0);
         cl = ($urandom_range(0, 2) == 0);
         rt = ($urandom_range(0, 3) == 0);
         d  = 16'($urandom);
         if ($urandom_range(0, 7) == 0) d = 16'hFFFF;
         drive(r, ld, ic, cl, rt, d);
         check_n++; if (out !== m_pc) $display("FAIL rnd_out_%0d got=%h exp=%h", n, out, m_pc); else pass_n++;
         check_n++;
         if (stack_full !== (m_stk.size() == DEPTH))
            $display("FAIL rnd_full_%0d got=%b exp=%b", n, stack_full, m_stk.size() == DEPTH);
         else pass_n++;
         check_n++;
         if (stack_empty !== (m_stk.size() == 0))
            $display("FAIL rnd_empty_%0d got=%b exp=%b", n, stack_empty, m_stk.size() == 0);
         else pass_n++;
         check_n++; if (stack_err !== m_err) $display("FAIL rnd_err_%0d got=%b exp=%b", n, stack_err, m_err); else pass_n++;
      end
   endtask

   initial begin
      reset = 1'b0; load = 1'b0; inc = 1'b0; call = 1'b0; ret = 1'b0; in = 16'h0;
      m_pc = RV; m_err = 1'b0;
      #2;
      test_reset;
      test_wrap;
      test_call_ret;
      test_stack_depth;
      test_simultaneous;
      test_random;
      $display("%0d/%0d checks passed", pass_n, check_n);
      $finish;
   end

endmodule
